elevator_task_scheduler: RTL and testbench
==========================================

Name: elevator_task_scheduler

Overview:
Queues parking-lot elevator tasks (car in, car out, leak-evacuation move) and sequences the single elevator through them. For each task the elevator travels to the source floor, loads the car, travels to the destination floor, then unloads. It sits between the request decoder/slot allocator and the elevator datapath in parking_lot_top. It drives current_floor, moving, the todo_* debug outputs and target_floor.

Parameters:
DEPTH, 4, entries in the normal-priority task FIFO (power of 2, at least 2)
PTR_W, 2, log2(DEPTH)

Ports:
clock  in  1  system clock; all logic updates on the rising edge
reset  in  1  synchronous, active-low
req_valid  in  1  a task is offered this cycle
req_type  in  2  0=IN, 1=OUT, 2=LEAK_MOVE; 3 is illegal and never accepted
req_plate  in  16  4-digit BCD license plate
req_src  in  3  pickup floor (0 for IN)
req_dst  in  3  drop floor (0 for OUT)
req_ready  out  1  task is accepted on this edge when req_valid and req_ready are both 1
current_floor  out  3  elevator position, 0..7
moving  out  16  plate currently aboard; 0 when the elevator is empty
target_floor  out  3  floor the elevator is heading to
todo_exists  out  1  a task is in progress
todo_in  out  1  in-progress task is IN
todo_out  out  1  in-progress task is OUT
todo_leak_move  out  1  in-progress task is LEAK_MOVE
todo_license_plate  out  16  plate of the in-progress task
task_done  out  1  one-cycle pulse when a task completes
fifo_count  out  PTR_W+1  occupancy of the normal FIFO

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; FIFO and leak slot flushed; all outputs 0, so current_floor=0, moving=0, fifo_count=0. Reset mid-task abandons the task; the car vanishes from moving and no task_done is produced.
- Storage: IN and OUT requests go to a DEPTH-entry FIFO. LEAK_MOVE requests go to a 1-entry high-priority leak slot.
- req_ready is combinational:
  - type 2: leak slot empty
  - type 0 or 1: FIFO not full
  - type 3: 0
- A FIFO push and pop on the same edge is legal when the FIFO is full, and count stays the same. A push is refused when full; there is no overwrite.
- FSM states: IDLE, GO_SRC, LOAD, GO_DST, UNLOAD.
  - IDLE: if the leak slot is valid, take it; else if the FIFO is non-empty, pop the head; else stay. Taking a task latches type/plate/src/dst into the task registers, sets todo_exists=1 and the matching todo_* flag, and moves to GO_SRC. The leak slot always wins over the FIFO.
  - GO_SRC: if current_floor != src, step current_floor by exactly ±1 toward src; else go to LOAD.
  - LOAD: moving <= task plate; go to GO_DST.
  - GO_DST: same stepping rule toward dst; when current_floor == dst, go to UNLOAD.
  - UNLOAD: moving <= 0; task_done <= 1; clear todo_*; go to IDLE.
- task_done is high for exactly one cycle.
- current_floor never changes by more than 1 per cycle, and never leaves 0..7.
- target_floor: src in GO_SRC, dst in GO_DST and LOAD, current_floor in IDLE and UNLOAD.
- Latency: from the pick edge to task_done high is d1+d2+5 edges, where d1=|floor_at_pick − src| and d2=|src−dst|. The elevator does not return to floor 0 between tasks.
- src==dst: still LOAD then UNLOAD, latency 5.
- A leak request arriving during a task waits until the current task's UNLOAD; there is no preemption.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset then idle: all outputs 0, req_ready=1 for types 0..2 and 0 for type 3. Pulsing reset during GO_DST clears the state and returns current_floor to 0 on the next edge.
- IN plate 9423 with src 0, dst 3, elevator at 0: moving=9423 after LOAD; floors 0→1→2→3; task_done 8 edges after the pick; moving=0 at the end.
- OUT plate 8754 with src 3, dst 0, starting at floor 3: d1=0, d2=3, done 8 edges after the pick; current_floor ends at 0.
- Fill the FIFO with 4 IN requests while busy: the 5th sees req_ready=0. A simultaneous push and pop when full is accepted and fifo_count stays 4. Tasks are serviced in FIFO order.
- FIFO holds 2 IN tasks, then LEAK_MOVE plate 5755 from 5 to 6 arrives during the active task: the leak task is picked right after the current task's UNLOAD, ahead of both queued tasks, with todo_leak_move=1.
- Task with src=dst=4 from floor 4: latency 5 edges, and current_floor never changes.

Source files
------------

// File: rtl/elevator_task_scheduler_if.sv
// Task request handshake between the request decoder and the elevator scheduler.
interface elevator_task_scheduler_if;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [15:0] req_plate;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic        req_ready;

    modport master (
        output req_valid, req_type, req_plate, req_src, req_dst,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_type, req_plate, req_src, req_dst,
        output req_ready
    );
endinterface

// File: rtl/elevator_task_scheduler.sv
// Elevator task sequencer: a normal IN/OUT FIFO plus one high-priority leak slot;
// each task travels to the source floor, loads, travels to the destination, unloads.
module elevator_task_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    elevator_task_scheduler_if.slave req,
    output logic [2:0]               current_floor,
    output logic [15:0]              moving,
    output logic [2:0]               target_floor,
    output logic                     todo_exists,
    output logic                     todo_in,
    output logic                     todo_out,
    output logic                     todo_leak_move,
    output logic [15:0]              todo_license_plate,
    output logic                     task_done,
    output logic [PTR_W:0]           fifo_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GO_SRC = 3'd1,
        S_LOAD   = 3'd2,
        S_GO_DST = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    logic [1:0]  r_fifo_type  [DEPTH];
    logic [15:0] r_fifo_plate [DEPTH];
    logic [2:0]  r_fifo_src   [DEPTH];
    logic [2:0]  r_fifo_dst   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic        r_leak_valid;
    logic [15:0] r_leak_plate;
    logic [2:0]  r_leak_src, r_leak_dst;

    logic [2:0]  r_task_src, r_task_dst;
    logic [2:0]  r_current_floor;
    logic [15:0] r_moving;
    logic        r_todo_exists, r_todo_in, r_todo_out, r_todo_leak_move;
    logic [15:0] r_todo_license_plate;
    logic        r_task_done;

    logic w_full, w_empty, w_take_leak, w_pop, w_req_ready;
    logic w_push_fifo, w_push_leak;
    logic [2:0] w_target_floor;

    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] goal);
        if (cur < goal)
            return cur + 3'd1;
        else if (cur > goal)
            return cur - 3'd1;
        return cur;
    endfunction

    assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_take_leak = (r_state == S_IDLE) && r_leak_valid;
    assign w_pop       = (r_state == S_IDLE) && !r_leak_valid && !w_empty;

    // A full FIFO still accepts a push on the same edge the head is popped.
    always_comb begin
        w_req_ready = 1'b0;
        case (req.req_type)
            2'd0, 2'd1: w_req_ready = !w_full || w_pop;
            2'd2:       w_req_ready = !r_leak_valid;
            default:    w_req_ready = 1'b0;
        endcase
    end

    assign req.req_ready = w_req_ready;
    assign w_push_fifo   = req.req_valid && w_req_ready && (req.req_type == 2'd0 || req.req_type == 2'd1);
    assign w_push_leak   = req.req_valid && w_req_ready && (req.req_type == 2'd2);

    always_comb begin
        w_state_next   = r_state;
        w_target_floor = r_current_floor;
        case (r_state)
            S_IDLE: begin
                if (w_take_leak || w_pop)
                    w_state_next = S_GO_SRC;
            end
            S_GO_SRC: begin
                w_target_floor = r_task_src;
                if (r_current_floor == r_task_src)
                    w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_target_floor = r_task_dst;
                w_state_next   = S_GO_DST;
            end
            S_GO_DST: begin
                w_target_floor = r_task_dst;
                if (r_current_floor == r_task_dst)
                    w_state_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state              <= S_IDLE;
            r_wr_ptr             <= '0;
            r_rd_ptr             <= '0;
            r_count              <= '0;
            r_leak_valid         <= 1'b0;
            r_current_floor      <= 3'd0;
            r_moving             <= 16'd0;
            r_todo_exists        <= 1'b0;
            r_todo_in            <= 1'b0;
            r_todo_out           <= 1'b0;
            r_todo_leak_move     <= 1'b0;
            r_todo_license_plate <= 16'd0;
            r_task_done          <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_task_done <= (r_state == S_UNLOAD);

            if (w_push_fifo)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_fifo, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_push_leak)
                r_leak_valid <= 1'b1;
            else if (w_take_leak)
                r_leak_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_take_leak) begin
                        r_todo_exists        <= 1'b1;
                        r_todo_leak_move     <= 1'b1;
                        r_todo_license_plate <= r_leak_plate;
                    end else if (w_pop) begin
                        r_todo_exists        <= 1'b1;
                        r_todo_in            <= (r_fifo_type[r_rd_ptr] == 2'd0);
                        r_todo_out           <= (r_fifo_type[r_rd_ptr] == 2'd1);
                        r_todo_license_plate <= r_fifo_plate[r_rd_ptr];
                    end
                end
                S_GO_SRC: r_current_floor <= step_toward(r_current_floor, r_task_src);
                S_LOAD:   r_moving        <= r_todo_license_plate;
                S_GO_DST: r_current_floor <= step_toward(r_current_floor, r_task_dst);
                S_UNLOAD: begin
                    r_moving             <= 16'd0;
                    r_todo_exists        <= 1'b0;
                    r_todo_in            <= 1'b0;
                    r_todo_out           <= 1'b0;
                    r_todo_leak_move     <= 1'b0;
                    r_todo_license_plate <= 16'd0;
                end
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in the pointers and flags above.
    always_ff @(posedge clock) begin
        if (w_push_fifo) begin
            r_fifo_type[r_wr_ptr]  <= req.req_type;
            r_fifo_plate[r_wr_ptr] <= req.req_plate;
            r_fifo_src[r_wr_ptr]   <= req.req_src;
            r_fifo_dst[r_wr_ptr]   <= req.req_dst;
        end
        if (w_push_leak) begin
            r_leak_plate <= req.req_plate;
            r_leak_src   <= req.req_src;
            r_leak_dst   <= req.req_dst;
        end
        if (w_take_leak) begin
            r_task_src <= r_leak_src;
            r_task_dst <= r_leak_dst;
        end else if (w_pop) begin
            r_task_src <= r_fifo_src[r_rd_ptr];
            r_task_dst <= r_fifo_dst[r_rd_ptr];
        end
    end

    assign current_floor      = r_current_floor;
    assign moving             = r_moving;
    assign target_floor       = w_target_floor;
    assign todo_exists        = r_todo_exists;
    assign todo_in            = r_todo_in;
    assign todo_out           = r_todo_out;
    assign todo_leak_move     = r_todo_leak_move;
    assign todo_license_plate = r_todo_license_plate;
    assign task_done          = r_task_done;
    assign fifo_count         = r_count;

endmodule

// File: tb/tb_elevator_task_scheduler.sv
// Scoreboard bench for elevator_task_scheduler: directed tasks push expected completions,
// a monitor pops and compares them on every task_done pulse.
module tb_elevator_task_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    elevator_task_scheduler_if bus();

    logic [2:0]  current_floor, target_floor;
    logic [15:0] moving, todo_license_plate;
    logic        todo_exists, todo_in, todo_out, todo_leak_move, task_done;
    logic [2:0]  fifo_count;

    elevator_task_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .req                (bus.slave),
        .current_floor      (current_floor),
        .moving             (moving),
        .target_floor       (target_floor),
        .todo_exists        (todo_exists),
        .todo_in            (todo_in),
        .todo_out           (todo_out),
        .todo_leak_move     (todo_leak_move),
        .todo_license_plate (todo_license_plate),
        .task_done          (task_done),
        .fifo_count         (fifo_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] plate;
        logic [1:0]  ttype;
        logic [2:0]  dst;
        int          lat;
        int          moves;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic add_exp(input logic [15:0] p, input logic [1:0] t, input logic [2:0] d,
                           input int lat, input int mv);
        exp_t e;
        e.plate = p; e.ttype = t; e.dst = d; e.lat = lat; e.moves = mv;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic        prev_exists = 1'b0, prev_done = 1'b0, in_task = 1'b0;
    logic [2:0]  prev_floor = 3'd0;
    logic [15:0] cap_plate = 16'd0, seen_mov = 16'd0;
    logic [1:0]  cap_type = 2'd0;
    int          pick_cyc = 0, moves = 0, df;
    exp_t        e;

    always @(posedge clock) begin
        #1;
        if (!reset) begin
            in_task = 1'b0;
        end else begin
            if (current_floor != prev_floor) begin
                df = int'(current_floor) - int'(prev_floor);
                chk("floor_step", (df == 1 || df == -1), 1);
                if (in_task) moves++;
            end
            if (todo_exists && !prev_exists) begin
                in_task   = 1'b1;
                pick_cyc  = cyc;
                moves     = 0;
                seen_mov  = 16'd0;
                cap_plate = todo_license_plate;
                cap_type  = todo_leak_move ? 2'd2 : (todo_out ? 2'd1 : 2'd0);
                chk("todo_onehot", 32'(todo_in) + 32'(todo_out) + 32'(todo_leak_move), 1);
            end
            if (in_task && moving != 16'd0) seen_mov = moving;
            if (task_done) begin
                chk("done_one_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got task_done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("plate", cap_plate, e.plate);
                    chk("type", cap_type, e.ttype);
                    chk("moving_aboard", seen_mov, e.plate);
                    chk("latency", cyc - pick_cyc + 1, e.lat);
                    chk("final_floor", current_floor, e.dst);
                    chk("floor_moves", moves, e.moves);
                    chk("moving_cleared", moving, 0);
                    chk("todo_cleared", {todo_exists, todo_in, todo_out, todo_leak_move}, 0);
                end
                in_task = 1'b0;
            end
        end
        prev_exists = todo_exists;
        prev_done   = task_done;
        prev_floor  = current_floor;
    end

    task automatic send(input logic [1:0] t, input logic [15:0] p, input logic [2:0] s,
                        input logic [2:0] d);
        int n;
        n = 0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_plate = p;
        bus.req_src   = s;
        bus.req_dst   = d;
        #1;
        while (!bus.req_ready && n < 60) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got req_ready=0 expected acceptance of plate %0h", p);
        end else begin
            @(posedge clock);
        end
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending tasks expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [3:0] ready_want;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_type  = 2'd0;
        bus.req_plate = 16'd0;
        bus.req_src   = 3'd0;
        bus.req_dst   = 3'd0;

        // Reset and idle outputs
        repeat (3) @(posedge clock);
        #1;
        chk("rst_floor", current_floor, 0);
        chk("rst_moving", moving, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_todo", {todo_exists, todo_in, todo_out, todo_leak_move}, 0);
        chk("rst_plate", todo_license_plate, 0);
        chk("rst_done", task_done, 0);
        chk("rst_target", target_floor, 0);
        @(negedge clock);
        reset = 1'b1;
        ready_want = 4'b0111;
        for (int t = 0; t < 4; t++) begin
            bus.req_type = 2'(t);
            #1;
            chk($sformatf("idle_ready_type%0d", t), bus.req_ready, ready_want[t]);
        end

        // IN 9423, floor 0 -> 3
        add_exp(16'h9423, 2'd0, 3'd3, 8, 3);
        send(2'd0, 16'h9423, 3'd0, 3'd3);
        wait_drain(40);

        // OUT 8754 from floor 3 down to 0
        add_exp(16'h8754, 2'd1, 3'd0, 8, 3);
        send(2'd1, 16'h8754, 3'd3, 3'd0);
        wait_drain(40);

        // Reset pulse during GO_DST abandons the task
        send(2'd0, 16'h1111, 3'd0, 3'd5);
        begin
            int n;
            n = 0;
            while (!(moving == 16'h1111 && current_floor == 3'd2) && n < 30) begin
                @(negedge clock);
                n++;
            end
            chk("reach_go_dst", (moving == 16'h1111 && current_floor == 3'd2), 1);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_floor", current_floor, 0);
        chk("midrst_moving", moving, 0);
        chk("midrst_todo", todo_exists, 0);
        chk("midrst_done", task_done, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(posedge clock);

        // Fill the FIFO while busy, then push into a full FIFO on the pop edge
        add_exp(16'h1000, 2'd0, 3'd7, 12, 7);
        send(2'd0, 16'h1000, 3'd0, 3'd7);
        add_exp(16'h1001, 2'd0, 3'd2, 14, 9);
        send(2'd0, 16'h1001, 3'd0, 3'd2);
        add_exp(16'h1002, 2'd0, 3'd1, 8, 3);
        send(2'd0, 16'h1002, 3'd0, 3'd1);
        add_exp(16'h1003, 2'd0, 3'd4, 10, 5);
        send(2'd0, 16'h1003, 3'd0, 3'd4);
        add_exp(16'h1004, 2'd0, 3'd6, 15, 10);
        send(2'd0, 16'h1004, 3'd0, 3'd6);
        @(negedge clock);
        chk("fifo_full_count", fifo_count, 4);
        bus.req_type = 2'd0;
        #1;
        chk("full_ready_in", bus.req_ready, 0);
        bus.req_type = 2'd1;
        #1;
        chk("full_ready_out", bus.req_ready, 0);
        bus.req_type = 2'd2;
        #1;
        chk("full_ready_leak", bus.req_ready, 1);
        add_exp(16'h1005, 2'd1, 3'd0, 11, 6);
        send(2'd1, 16'h1005, 3'd6, 3'd0);
        chk("push_pop_full_count", fifo_count, 4);
        wait_drain(200);

        // Leak task overtakes two queued IN tasks
        add_exp(16'h2001, 2'd0, 3'd3, 8, 3);
        send(2'd0, 16'h2001, 3'd0, 3'd3);
        add_exp(16'h5755, 2'd2, 3'd6, 8, 3);
        add_exp(16'h2002, 2'd0, 3'd2, 13, 8);
        add_exp(16'h2003, 2'd0, 3'd1, 8, 3);
        send(2'd0, 16'h2002, 3'd0, 3'd2);
        send(2'd0, 16'h2003, 3'd0, 3'd1);
        send(2'd2, 16'h5755, 3'd5, 3'd6);
        chk("leak_waits", todo_leak_move, 0);
        wait_drain(120);

        // Move to floor 4, then a src==dst task there
        add_exp(16'h7001, 2'd0, 3'd4, 8, 3);
        send(2'd0, 16'h7001, 3'd1, 3'd4);
        wait_drain(40);
        add_exp(16'h4444, 2'd0, 3'd4, 5, 0);
        send(2'd0, 16'h4444, 3'd4, 3'd4);
        wait_drain(40);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
